encode_set: RTL and testbench

Inverse of the decode-set packer for the FrodoKEM-style datapath. It accepts packed B-bit message symbols as 64-bit words and unpacks them into four 16-bit coefficient lanes per output word, scaling each symbol by q/2^B. The selected level sets B and the word counts:

- level 0 (640): B=2, q=2^15.
- level 1 (976): B=3, q=2^16.
- level 2 (1344): B=4, q=2^16.

Every block produces 16 output words. The block sits between the message/key buffer and the matrix-add stage.

---
 rtl/encode_set.sv | 170 +++++++++++++++++
 tb/tb_encode_set.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_set.sv
// encode_set: unpacks left-justified B-bit message symbols into four 16-bit
// coefficient lanes per output word, scaling each symbol by q/2^B.
// A block is 2, 3 or 4 input words (level 0, 1, 2) followed by 16 output words.
module encode_set (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sec_lvl,
  input  logic [63:0] msg,
  input  logic        msg_val,
  output logic        ready,
  input  logic        out_ready,
  output logic [63:0] encodeOut,
  output logic        encodeOut_val
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    LVL_640  = 2'd0,
    LVL_976  = 2'd1,
    LVL_1344 = 2'd2,
    LVL_BAD  = 2'd3
  } lvl_e;

  state_e       state;
  lvl_e         lvl;
  logic [1:0]   in_cnt;
  logic [3:0]   out_cnt;
  logic [255:0] buffer;

  lvl_e         lvl_eff;
  logic [1:0]   last_in;
  logic [255:0] buf_loaded;
  logic [255:0] buf_shifted;

  // Build one output word from the top of the buffer for the given level.
  // For level 1, odd selects word B of the current 24-bit group.
  function automatic logic [63:0] encode_word(input logic [255:0] b,
                                              input lvl_e         l,
                                              input logic         odd);
    logic [23:0] g;
    logic [2:0]  a0, a1, a2, a3;
    logic [2:0]  b0, b1, b2, b3;
    logic [63:0] w;
    g  = b[255:232];
    a0 = g[11:9];
    a1 = {g[8], g[23:22]};
    a2 = g[21:19];
    a3 = g[18:16];
    b0 = g[7:5];
    b1 = g[4:2];
    b2 = {g[1:0], g[15]};
    b3 = g[14:12];
    w  = '0;
    case (l)
      // 2-bit symbols from the top byte, MSB pair is lane 0.
      LVL_640: w = {1'b0, b[249:248], 13'h0,
                    1'b0, b[251:250], 13'h0,
                    1'b0, b[253:252], 13'h0,
                    1'b0, b[255:254], 13'h0};
      // 4-bit symbols with the two bit-pairs of each nibble swapped.
      LVL_1344: w = {b[241:240], b[243:242], 12'h0,
                     b[245:244], b[247:246], 12'h0,
                     b[249:248], b[251:250], 12'h0,
                     b[253:252], b[255:254], 12'h0};
      // 3-bit symbols interleaved across a 24-bit group shared by A and B.
      LVL_976: w = odd ? {b3, 13'h0, b2, 13'h0, b1, 13'h0, b0, 13'h0}
                       : {a3, 13'h0, a2, 13'h0, a1, 13'h0, a0, 13'h0};
      default: w = '0;
    endcase
    return w;
  endfunction

  // The level is taken live for the first word of a block, latched afterwards.
  always_comb begin
    lvl_eff = (in_cnt == 2'd0) ? lvl_e'(sec_lvl) : lvl;
  end

  assign ready = (state == S_LOAD) && (lvl_eff != LVL_BAD);

  // Index of the final input word of a block for the effective level.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    last_in = 2'd3;
    case (lvl_eff)
      LVL_640:  last_in = 2'd1;
      LVL_976:  last_in = 2'd2;
      LVL_1344: last_in = 2'd3;
      default:  last_in = 2'd3;
    endcase
  end

  // Buffer image with the incoming word dropped into its left-justified slot.
  always_comb begin
    buf_loaded = buffer;
    case (in_cnt)
      2'd0:    buf_loaded[255:192] = msg;
      2'd1:    buf_loaded[191:128] = msg;
      2'd2:    buf_loaded[127:64]  = msg;
      default: buf_loaded[63:0]    = msg;
    endcase
  end

  // Buffer image after the current output word has been consumed.
  // Level 1 keeps the group in place after word A since word B reuses it.
  always_comb begin
    buf_shifted = buffer;
    case (lvl)
      LVL_640:  buf_shifted = {buffer[247:0], 8'h0};
      LVL_1344: buf_shifted = {buffer[239:0], 16'h0};
      LVL_976:  buf_shifted = out_cnt[0] ? {buffer[231:0], 24'h0} : buffer;
      default:  buf_shifted = buffer;
    endcase
  end

  // Block FSM: collect N_in words, then emit 16 registered output words.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide buffer is reset too, so a block cut short by reset leaves no stale symbols behind.
      state         <= S_LOAD;
      lvl           <= LVL_640;
      in_cnt        <= '0;
      out_cnt       <= '0;
      buffer        <= '0;
      encodeOut     <= '0;
      encodeOut_val <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_LOAD: begin
          if (msg_val && ready) begin
            buffer <= buf_loaded;
            if (in_cnt == 2'd0) begin
              lvl <= lvl_eff;
            end
            if (in_cnt == last_in) begin
              state         <= S_EMIT;
              in_cnt        <= '0;
              encodeOut     <= encode_word(buf_loaded, lvl_eff, 1'b0);
              encodeOut_val <= 1'b1;
            end else begin
              in_cnt <= in_cnt + 2'd1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (out_cnt == 4'd15) begin
              state         <= S_LOAD;
              out_cnt       <= '0;
              in_cnt        <= '0;
              buffer        <= '0;
              encodeOut     <= '0;
              encodeOut_val <= 1'b0;
            end else begin
              out_cnt   <= out_cnt + 4'd1;
              buffer    <= buf_shifted;
              encodeOut <= encode_word(buf_shifted, lvl, ~out_cnt[0]);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_set.sv
// tb_encode_set: directed blocks for every level; expected words are pushed
// into a scoreboard queue and a monitor compares each presented output word.
module tb_encode_set;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sec_lvl;
  logic [63:0] msg;
  logic        msg_val;
  logic        ready;
  logic        out_ready;
  logic [63:0] encodeOut;
  logic        encodeOut_val;

  int          tests   = 0;
  int          fails   = 0;
  int          pop_cnt = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  encode_set dut (
    .clk           (clk),
    .rst           (rst),
    .sec_lvl       (sec_lvl),
    .msg           (msg),
    .msg_val       (msg_val),
    .ready         (ready),
    .out_ready     (out_ready),
    .encodeOut     (encodeOut),
    .encodeOut_val (encodeOut_val)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented word against the queue head; pop on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("ready_val_exclusive", 64'(ready & encodeOut_val), 64'd0);
        if (encodeOut_val) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_val", 64'(encodeOut_val), 64'd0);
          end else begin
            check($sformatf("out_word_%0d", pop_cnt % 16), encodeOut, exp_q[0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              pop_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic send_word(input logic [63:0] w);
    bit done;
    done    = 1'b0;
    msg     = w;
    msg_val = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = ready;
      tick();
    end
    msg_val = 1'b0;
    msg     = '0;
    check("send_accepted", 64'(done), 64'd1);
  endtask

  // Push the 16 expected words, then feed the block's input words.
  // sec_lvl is disturbed after the first word; the latched level must win.
  task automatic load_block(input logic [1:0] lvl, input logic [63:0] w[4],
                            input logic [63:0] e[16]);
    int n;
    n = int'(lvl) + 2;
    for (int i = 0; i < 16; i++) exp_q.push_back(e[i]);
    sec_lvl = lvl;
    for (int i = 0; i < n; i++) begin
      send_word(w[i]);
      if (i == 0) sec_lvl = lvl + 2'd1;
    end
    sec_lvl = lvl;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_ready_after"}, 64'(ready), 64'd1);
    check({name, "_val_after"}, 64'(encodeOut_val), 64'd0);
  endtask

  initial begin
    logic [63:0] w[4];
    logic [63:0] e[16];
    int          base;
    int          k;

    rst       = 1'b1;
    sec_lvl   = 2'd0;
    msg       = '0;
    msg_val   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("reset_val", 64'(encodeOut_val), 64'd0);
    check("reset_out", encodeOut, 64'd0);
    rst = 1'b0;
    check("reset_ready", 64'(ready), 64'd1);
    tick();

    // lvl0 single symbol in lane order c0..c3 = 3,2,1,0
    w = '{64'hE400_0000_0000_0000, 64'h0, 64'h0, 64'h0};
    e = '{default: 64'h0};
    e[0] = 64'h0000_2000_4000_6000;
    load_block(2'd0, w, e);
    drain("lvl0_single");

    // lvl0 reversed lanes in the first byte, second word feeding the last output
    w = '{64'h1B00_0000_0000_0000, 64'h0000_0000_0000_00E4, 64'h0, 64'h0};
    e = '{default: 64'h0};
    e[0]  = 64'h6000_4000_2000_0000;
    e[15] = 64'h0000_2000_4000_6000;
    load_block(2'd0, w, e);
    drain("lvl0_lanes");

    // lvl2 nibble swap at the first and last output word
    w = '{64'h1234_0000_0000_0000, 64'h0, 64'h0, 64'h0000_0000_0000_1234};
    e = '{default: 64'h0};
    e[0]  = 64'h1000_C000_8000_4000;
    e[15] = 64'h1000_C000_8000_4000;
    load_block(2'd2, w, e);
    drain("lvl2_swap");

    // lvl1 all ones
    w = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    e = '{default: 64'hE000_E000_E000_E000};
    load_block(2'd1, w, e);
    drain("lvl1_ones");

    // lvl1 only G[23] set: a1 bit 1
    w = '{64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0};
    e = '{default: 64'h0};
    e[0] = 64'h0000_0000_4000_0000;
    load_block(2'd1, w, e);
    drain("lvl1_g23");

    // lvl1 field map: G=0x6E00A9 gives A={6,5,1,0}, B={0,2,2,5}; last group all ones
    w = '{64'h6E00_A900_0000_0000, 64'h0, 64'h0000_0000_00FF_FFFF, 64'h0};
    e = '{default: 64'h0};
    e[0]  = 64'hC000_A000_2000_0000;
    e[1]  = 64'h0000_4000_4000_A000;
    e[14] = 64'hE000_E000_E000_E000;
    e[15] = 64'hE000_E000_E000_E000;
    load_block(2'd1, w, e);
    drain("lvl1_fields");

    // lvl1 the other half of G: b2[0], b3, a0, a1[2]
    w = '{64'h00FF_0000_0000_0000, 64'h0, 64'h0, 64'h0};
    e = '{default: 64'h0};
    e[0] = 64'h0000_0000_8000_E000;
    e[1] = 64'hE000_2000_0000_0000;
    load_block(2'd1, w, e);
    drain("lvl1_mid");

    // Backpressure on word 5 for 3 cycles while sec_lvl wanders
    w = '{64'h0000_0000_00E4_0000, 64'h0, 64'h0, 64'h0};
    e = '{default: 64'h0};
    e[5] = 64'h0000_2000_4000_6000;
    base = pop_cnt;
    load_block(2'd0, w, e);
    k = 0;
    while (pop_cnt - base < 5 && k < 100) begin
      tick();
      k++;
    end
    check("bp_reached_word5", 64'(pop_cnt - base), 64'd5);
    out_ready = 1'b0;
    sec_lvl   = 2'd2;
    tick();
    check("bp_ready_low", 64'(ready), 64'd0);
    sec_lvl = 2'd3;
    tick();
    check("bp_val_held", 64'(encodeOut_val), 64'd1);
    sec_lvl = 2'd1;
    tick();
    check("bp_no_pop", 64'(pop_cnt - base), 64'd5);
    out_ready = 1'b1;
    sec_lvl   = 2'd0;
    drain("backpressure");
    check("bp_total_transfers", 64'(pop_cnt - base), 64'd16);

    // Reset after one of two lvl0 words: nothing may come out
    sec_lvl = 2'd0;
    send_word(64'hFFFF_FFFF_FFFF_FFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_val", 64'(encodeOut_val), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    repeat (4) tick();

    // Fresh block after the reset decodes from new data only
    w = '{64'hE400_0000_0000_0000, 64'h0, 64'h0, 64'h0};
    e = '{default: 64'h0};
    e[0] = 64'h0000_2000_4000_6000;
    load_block(2'd0, w, e);
    drain("after_reset");

    // Invalid level: never ready, never valid
    sec_lvl = 2'd3;
    msg     = 64'hFFFF_FFFF_FFFF_FFFF;
    msg_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("invalid_ready", 64'(ready), 64'd0);
    end
    check("invalid_val", 64'(encodeOut_val), 64'd0);
    msg_val = 1'b0;
    msg     = '0;
    sec_lvl = 2'd0;
    tick();
    check("invalid_recover_ready", 64'(ready), 64'd1);

    repeat (5) tick();
    check("queue_empty_end", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
